// File: rtl/reset_request_gen.sv
// reset_request_gen: board-side reset source. Merges power-on hold, a debounced
// reset push-button, a CPU soft-reset request and an optional watchdog into a
// single registered active-low reset request with a guaranteed minimum low width.
// Records the cause of the most recent reset for software.
//
// Optional feature: define RESET_WDT_EN to add the wdt_kick port and the
// watchdog counter. Without it, cause 2'b11 is never produced.
module reset_request_gen #(
  parameter int SYNC_STAGES     = 2,    // >= 2
  parameter int DEBOUNCE_CYCLES = 16,   // >= 2
  parameter int POR_CYCLES      = 32,
  parameter int MIN_PULSE       = 8,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       button_n,
  input  logic       soft_reset,
`ifdef RESET_WDT_EN
  input  logic       wdt_kick,
`endif
  output logic       reset_req_n,
  output logic [1:0] reset_cause,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_POR      = 2'd0,
    ST_RUN      = 2'd1,
    ST_ASSERT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_SOFT   = 2'b10;
  localparam logic [1:0] CAUSE_WDT    = 2'b11;

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_MAX = (POR_CYCLES > MIN_PULSE) ? POR_CYCLES - 1 : MIN_PULSE - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_b;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   deb;
  logic                   deb_d;
  logic                   press_q;
  logic                   wdt_event;

  state_t     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic       req_n_next;
  logic [1:0] cause_next;
  logic       busy_next;

  assign sync_b = sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous button into the clock domain; released (1) in reset.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_in) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
  end

  // Debounce: the level only changes after it differs for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else if (sync_b == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb     <= sync_b;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Registered one-cycle press pulse on the debounced 1->0 transition.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      deb_d   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      deb_d   <= deb;
      press_q <= deb_d & ~deb;
    end
  end

`ifdef RESET_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES);
  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_event = (state == ST_RUN) && !wdt_kick &&
                     (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  // Watchdog: runs only in RUN, restarted by a kick; expiry is consumed by the FSM.
  always_ff @(posedge clk) begin
    if (!reset_in || wdt_kick || state != ST_RUN || wdt_event) wdt_cnt <= '0;
    else                                                       wdt_cnt <= wdt_cnt + 1'b1;
  end
`else
  assign wdt_event = 1'b0;
`endif

  // Next-state and registered-output logic for the reset sequencer.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_n_next = reset_req_n;
    cause_next = reset_cause;
    case (state)
      ST_POR: begin
        req_n_next = 1'b0;
        if (cnt == CNT_W'(POR_CYCLES - 1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          req_n_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        req_n_next = 1'b1;
        if (press_q || wdt_event || soft_reset) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          req_n_next = 1'b0;
          if (press_q)        cause_next = CAUSE_BUTTON;
          else if (wdt_event) cause_next = CAUSE_WDT;
          else                cause_next = CAUSE_SOFT;
        end
      end
      ST_ASSERT: begin
        req_n_next = 1'b0;
        if (cnt == CNT_W'(MIN_PULSE - 1)) begin
          cnt_next = '0;
          if (deb) begin
            state_next = ST_RUN;
            req_n_next = 1'b1;
          end else begin
            state_next = ST_WAIT_REL;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        req_n_next = 1'b0;
        if (deb) begin
          state_next = ST_RUN;
          req_n_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_POR;
        cnt_next   = '0;
        req_n_next = 1'b0;
      end
    endcase
    busy_next = (state_next != ST_RUN);
  end

  // State, counter and output registers; reset_in forces the power-on sequence.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state       <= ST_POR;
      cnt         <= '0;
      reset_req_n <= 1'b0;
      reset_cause <= CAUSE_POR;
      busy        <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      reset_req_n <= req_n_next;
      reset_cause <= cause_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed testbench for reset_request_gen with default parameters.
// Define RESET_WDT_EN to build and exercise the watchdog variant.
module tb_reset_request_gen;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       button_n;
  logic       soft_reset;
`ifdef RESET_WDT_EN
  logic       wdt_kick;
`endif
  logic       reset_req_n;
  logic [1:0] reset_cause;
  logic       busy;

  int checks = 0;
  int errors = 0;

  reset_request_gen dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .button_n    (button_n),
    .soft_reset  (soft_reset),
`ifdef RESET_WDT_EN
    .wdt_kick    (wdt_kick),
`endif
    .reset_req_n (reset_req_n),
    .reset_cause (reset_cause),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // One clock edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int n;
    reset_in = 1'b0;
    ticks(5);
    checks++; if (reset_req_n !== 1'b0) begin errors++; $display("FAIL reset_req_n: got %b expected 0", reset_req_n); end
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b expected 00", reset_cause); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    reset_in = 1'b1;
    n = 0;
    while (reset_req_n !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != 32) begin errors++; $display("FAIL por_width: got %0d expected 32", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL por_busy_after: got %b expected 0", busy); end
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL por_cause: got %b expected 00", reset_cause); end
  endtask

  task automatic test_bounce();
    bit seen_low = 1'b0;
    button_n = 1'b0;
    repeat (10) begin tick(); if (reset_req_n !== 1'b1) seen_low = 1'b1; end
    button_n = 1'b1;
    repeat (40) begin tick(); if (reset_req_n !== 1'b1) seen_low = 1'b1; end
    checks++; if (seen_low) begin errors++; $display("FAIL bounce_no_reset: got low expected stay high"); end
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL bounce_cause: got %b expected 00", reset_cause); end
  endtask

  task automatic test_button();
    int n;
    button_n = 1'b0;
    n = 0;
    while (reset_req_n !== 1'b0 && n < 100) begin tick(); n++; end
    // Low appears 19 edges after the first sampling edge (tick 1), i.e. on tick 20.
    checks++; if (n != 20) begin errors++; $display("FAIL button_latency: got %0d ticks expected 20", n); end
    checks++; if (reset_cause !== 2'b01) begin errors++; $display("FAIL button_cause: got %b expected 01", reset_cause); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL button_busy: got %b expected 1", busy); end
    ticks(20);
    checks++; if (reset_req_n !== 1'b0) begin errors++; $display("FAIL button_held: got %b expected 0", reset_req_n); end
    button_n = 1'b1;
    n = 0;
    while (reset_req_n !== 1'b1 && n < 200) begin tick(); n++; end
    // Release: 2 sync + 16 debounce edges, then WAIT_REL exits on the next edge.
    checks++; if (n != 19) begin errors++; $display("FAIL button_release: got %0d ticks expected 19", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL button_busy_after: got %b expected 0", busy); end
    checks++; if (reset_cause !== 2'b01) begin errors++; $display("FAIL button_cause_hold: got %b expected 01", reset_cause); end
  endtask

  task automatic test_soft();
    int w;
    ticks(3);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    checks++; if (reset_req_n !== 1'b0) begin errors++; $display("FAIL soft_latency: got %b expected 0", reset_req_n); end
    checks++; if (reset_cause !== 2'b10) begin errors++; $display("FAIL soft_cause: got %b expected 10", reset_cause); end
    w = 1;
    for (int i = 1; i <= 20; i++) begin
      soft_reset = (i == 3);
      tick();
      if (reset_req_n === 1'b0) w++;
    end
    soft_reset = 1'b0;
    checks++; if (w != 8) begin errors++; $display("FAIL soft_width: got %0d expected 8", w); end
    checks++; if (reset_cause !== 2'b10) begin errors++; $display("FAIL soft_cause_hold: got %b expected 10", reset_cause); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL soft_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_collision_and_abort();
    int n;
    ticks(3);
    button_n = 1'b0;
    ticks(19);
    checks++; if (reset_req_n !== 1'b1) begin errors++; $display("FAIL coll_pre: got %b expected 1", reset_req_n); end
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    checks++; if (reset_req_n !== 1'b0) begin errors++; $display("FAIL coll_req: got %b expected 0", reset_req_n); end
    checks++; if (reset_cause !== 2'b01) begin errors++; $display("FAIL coll_cause: got %b expected 01", reset_cause); end
    ticks(3);
    reset_in = 1'b0;
    tick();
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL abort_cause: got %b expected 00", reset_cause); end
    checks++; if (reset_req_n !== 1'b0) begin errors++; $display("FAIL abort_req: got %b expected 0", reset_req_n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
    button_n = 1'b1;
    ticks(3);
    reset_in = 1'b1;
    n = 0;
    while (reset_req_n !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != 32) begin errors++; $display("FAIL abort_por_width: got %0d expected 32", n); end
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL abort_cause_hold: got %b expected 00", reset_cause); end
  endtask

`ifdef RESET_WDT_EN
  task automatic test_wdt();
    int  n;
    bit  seen_low = 1'b0;
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    n = 0;
    while (reset_req_n !== 1'b0 && n < 2000) begin tick(); n++; end
    checks++; if (n != 1024) begin errors++; $display("FAIL wdt_expiry: got %0d ticks expected 1024", n); end
    checks++; if (reset_cause !== 2'b11) begin errors++; $display("FAIL wdt_cause: got %b expected 11", reset_cause); end
    n = 0;
    while (reset_req_n !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL wdt_width: got %0d expected 8", n); end
    repeat (3) begin
      repeat (999) begin tick(); if (reset_req_n !== 1'b1) seen_low = 1'b1; end
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      if (reset_req_n !== 1'b1) seen_low = 1'b1;
    end
    checks++; if (seen_low) begin errors++; $display("FAIL wdt_kicked: got low expected stay high"); end
  endtask
`endif

  initial begin
    reset_in   = 1'b0;
    button_n   = 1'b1;
    soft_reset = 1'b0;
`ifdef RESET_WDT_EN
    wdt_kick   = 1'b0;
`endif
    test_reset();
    test_bounce();
    test_button();
    test_soft();
    test_collision_and_abort();
`ifdef RESET_WDT_EN
    test_wdt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
